// File: rtl/req_ack_done_arbiter_if.sv
// Purpose : client/resource handshake bundle for req_ack_done_arbiter.
// Latency : n/a (wires only).
// Backpressure: n/a; the resource throttles the arbiter through rsc_ack/rsc_done.
//
// Signals:
//   req      [N]  per-client request level             (clients -> arbiter)
//   gnt      [N]  one-hot grant, held per transaction   (arbiter -> clients)
//   cli_done [N]  one-cycle completion pulse            (arbiter -> clients)
//   rsc_req       request to the shared resource        (arbiter -> resource)
//   rsc_ack       resource acknowledge                  (resource -> arbiter)
//   rsc_done      resource completion                   (resource -> arbiter)
//   busy          arbiter not idle                      (arbiter -> observers)
//   err/err_code  one-cycle error pulse + cause         (arbiter -> observers)
// Modports: slave = arbiter side, master = client/resource environment side.
interface req_ack_done_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] cli_done;
  logic         rsc_req;
  logic         rsc_ack;
  logic         rsc_done;
  logic         busy;
  logic         err;
  logic [1:0]   err_code;

  modport slave (
    input  req, rsc_ack, rsc_done,
    output gnt, cli_done, rsc_req, busy, err, err_code
  );

  modport master (
    output req, rsc_ack, rsc_done,
    input  gnt, cli_done, rsc_req, busy, err, err_code
  );
endinterface

// File: rtl/req_ack_done_arbiter.sv
// Purpose : round-robin arbiter/sequencer granting N clients one shared req/ack/done resource.
// Latency : grant 1 cycle after req seen in IDLE; cli_done/err 1 cycle after done/window expiry.
// Backpressure: waits on rsc_ack (unbounded unless the ack timeout is built in), done window bounded.
//
// Ports: clk, rst (async active-high), bus (req_ack_done_arbiter_if.slave: req, gnt,
//        cli_done, rsc_req, rsc_ack, rsc_done, busy, err, err_code).
// Optional macro REQ_ACK_DONE_ARB_ACK_TIMEOUT_EN: abort with err_code 10 when rsc_ack does
// not arrive within ACK_TIMEOUT cycles of rsc_req rising. Undefined: REQ waits forever.
module req_ack_done_arbiter #(
  parameter int N           = 4,
  parameter int DONE_WIN    = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  req_ack_done_arbiter_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int DW = (DONE_WIN > 1) ? $clog2(DONE_WIN) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  if (N < 2 || N > 16 || DONE_WIN < 1 || ACK_TIMEOUT < 1) begin : g_bad_params
    $error("req_ack_done_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    gnt_r;
  logic [N-1:0]    cli_done_r;
  logic            rsc_req_r;
  logic            busy_r;
  logic            err_r;
  logic [1:0]      err_code_r;
  logic [IW-1:0]   last_winner;
  logic [DW-1:0]   win_cnt;     // cycles already spent in WAIT_DONE (k-1)
`ifdef REQ_ACK_DONE_ARB_ACK_TIMEOUT_EN
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  logic [AW-1:0]   ack_cnt;     // cycles rsc_req has been high without ack, minus one
`endif

  // Round-robin pick: first requesting client scanning upward from last_winner+1 with wrap.
  logic [IW-1:0] win_idx;
  logic [IW-1:0] scan_idx;
  logic          win_found;

  always_comb begin
    win_idx   = last_winner;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int i = 1; i <= N; i++) begin
      scan_idx = IW'((int'(last_winner) + i) % N);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt_r       <= '0;
      cli_done_r  <= '0;
      rsc_req_r   <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= 2'b00;
      last_winner <= IW'(N - 1);   // client 0 scanned first after reset
      win_cnt     <= '0;
`ifdef REQ_ACK_DONE_ARB_ACK_TIMEOUT_EN
      ack_cnt     <= '0;
`endif
    end else begin
      // Pulses last a single cycle.
      cli_done_r <= '0;
      err_r      <= 1'b0;
      err_code_r <= 2'b00;

      case (state)
        IDLE: begin
          // rsc_done seen here is stray and ignored.
          if (win_found) begin
            gnt_r       <= ONE << win_idx;
            rsc_req_r   <= 1'b1;
            busy_r      <= 1'b1;
            last_winner <= win_idx;
            state       <= REQ;
`ifdef REQ_ACK_DONE_ARB_ACK_TIMEOUT_EN
            ack_cnt     <= '0;
`endif
          end
        end

        REQ: begin
          // Done must follow ack strictly, so rsc_done is not looked at here.
          if (bus.rsc_ack) begin
            rsc_req_r <= 1'b0;
            win_cnt   <= '0;
            state     <= WAIT_DONE;
          end
`ifdef REQ_ACK_DONE_ARB_ACK_TIMEOUT_EN
          else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
            // Abandon the client; last_winner already points at it, so the next
            // scan starts past it.
            rsc_req_r  <= 1'b0;
            gnt_r      <= '0;
            busy_r     <= 1'b0;
            err_r      <= 1'b1;
            err_code_r <= 2'b10;
            state      <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
`endif
        end

        WAIT_DONE: begin
          // A repeated rsc_ack is ignored; only rsc_done matters.
          if (bus.rsc_done) begin
            cli_done_r <= gnt_r;
            gnt_r      <= '0;
            busy_r     <= 1'b0;
            state      <= IDLE;
          end else if (win_cnt == DW'(DONE_WIN - 1)) begin
            gnt_r      <= '0;
            busy_r     <= 1'b0;
            err_r      <= 1'b1;
            err_code_r <= 2'b01;
            state      <= IDLE;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          gnt_r     <= '0;
          rsc_req_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.cli_done = cli_done_r;
  assign bus.rsc_req  = rsc_req_r;
  assign bus.busy     = busy_r;
  assign bus.err      = err_r;
  assign bus.err_code = err_code_r;

endmodule

// File: tb/tb_req_ack_done_arbiter.sv
// Purpose : self-checking bench for req_ack_done_arbiter (N=4, DONE_WIN=2, ACK_TIMEOUT=4).
// Latency : each vector row drives one cycle of inputs; its expected outputs are checked after the edge.
// Backpressure: none; the bench plays both the clients and the resource.
module tb_req_ack_done_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  req_ack_done_arbiter_if #(.N(N)) bus ();

  req_ack_done_arbiter #(
    .N           (N),
    .DONE_WIN    (2),
    .ACK_TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [N-1:0] cli_done;
    logic         rsc_req;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;
  } out_t;

  typedef struct packed {
    logic [N-1:0] req;
    logic         ack;
    logic         done;
    out_t         exp;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic out_t sample();
    out_t o;
    o.gnt      = bus.gnt;
    o.cli_done = bus.cli_done;
    o.rsc_req  = bus.rsc_req;
    o.busy     = bus.busy;
    o.err      = bus.err;
    o.err_code = bus.err_code;
    return o;
  endfunction

  // One row: inputs for this cycle, outputs expected right after the next rising edge.
  function automatic void add(input logic [N-1:0] req, input logic ack, input logic done,
                              input logic [N-1:0] g, input logic [N-1:0] cd,
                              input logic rr, input logic b, input logic e,
                              input logic [1:0] code);
    vec_t v;
    v.req          = req;
    v.ack          = ack;
    v.done         = done;
    v.exp.gnt      = g;
    v.exp.cli_done = cd;
    v.exp.rsc_req  = rr;
    v.exp.busy     = b;
    v.exp.err      = e;
    v.exp.err_code = code;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input out_t got, input out_t want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b cli_done=%b rsc_req=%b busy=%b err=%b err_code=%b ; want gnt=%b cli_done=%b rsc_req=%b busy=%b err=%b err_code=%b",
               name, got.gnt, got.cli_done, got.rsc_req, got.busy, got.err, got.err_code,
               want.gnt, want.cli_done, want.rsc_req, want.busy, want.err, want.err_code);
    end
  endtask

  task automatic run_vecs(input string name);
    vec_t v;
    int   idx;
    idx = 0;
    while (vecs.size() > 0) begin
      v = vecs.pop_front();
      bus.req      = v.req;
      bus.rsc_ack  = v.ack;
      bus.rsc_done = v.done;
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", name, idx), sample(), exp_q.pop_front());
      idx++;
    end
    bus.req      = '0;
    bus.rsc_ack  = 1'b0;
    bus.rsc_done = 1'b0;
  endtask

  initial begin
    out_t zero;
    logic [N-1:0] g;
    zero = '0;

    rst          = 1'b1;
    bus.req      = '0;
    bus.rsc_ack  = 1'b0;
    bus.rsc_done = 1'b0;
    #2;
    check("reset_state", sample(), zero);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fairness: all four request continuously; ack after one cycle, done one after that.
    for (int t = 0; t < 5; t++) begin
      g = 4'b0001 << (t % 4);
      add(4'b1111, 1'b0, 1'b0, g,  4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
      add(4'b1111, 1'b1, 1'b0, g,  4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);
      add(4'b1111, 1'b0, 1'b1, '0, g,       1'b0, 1'b0, 1'b0, 2'b00);
    end
    run_vecs("fairness");

    // Single client, dropping req after the grant; early done during REQ is ignored.
    add(4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
    run_vecs("single");

    // Done window missed: done first at a+3; repeated ack in WAIT_DONE ignored; late done ignored.
    add(4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b01);
    add(4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
    run_vecs("done_late");

    // Ack and done together: done ignored, then done at a+1 completes.
    add(4'b1000, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b1, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
    run_vecs("ack_done_same");

`ifdef REQ_ACK_DONE_ARB_ACK_TIMEOUT_EN
    // No ack: rsc_req high 4 cycles, then err_code 10; next client after one IDLE cycle.
    add(4'b0110, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++)
      add(4'b0110, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    add(4'b0110, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b10);
    add(4'b0110, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
    run_vecs("ack_timeout");
`else
    // No ack for a long stretch: REQ holds with no error, then completes normally.
    add(4'b0110, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 8; i++)
      add(4'b0110, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    add(4'b0110, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
    run_vecs("ack_wait");
`endif

    // Enter WAIT_DONE, then assert reset between clock edges.
    add(4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);
    run_vecs("pre_reset");
    rst = 1'b1;
    #2;
    check("async_reset", sample(), zero);
    @(posedge clk);
    #1;
    check("reset_held", sample(), zero);
    rst = 1'b0;

    // After reset client 0 has top priority, then client 3 follows.
    add(4'b1001, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b00);
    add(4'b1000, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00);
    add(4'b1000, 1'b1, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 2'b00);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00);
    run_vecs("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/req_ack_done_arbiter.md
Name: req_ack_done_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared resource that uses a req/ack/done handshake.
- Collects requests from N clients and grants exactly one client at a time.
- Drives the resource request and waits (unbounded by default) for ack.
- Requires done within a bounded window after ack, then returns a per-client completion pulse or flags an error.

Parameters:
- N, 4: number of requesting clients (2..16).
- DONE_WIN, 2: done must arrive 1..DONE_WIN cycles after the ack cycle.
- ACK_TIMEOUT, 16: max cycles rsc_req may be held without ack (used only with the optional feature).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-client request level.
- gnt  output  N  one-hot grant, held for the whole transaction.
- cli_done  output  N  one-cycle pulse to the granted client on successful completion.
- rsc_req  output  1  request to the resource.
- rsc_ack  input  1  resource acknowledge.
- rsc_done  input  1  resource completion.
- busy  output  1  high when the state is not IDLE.
- err  output  1  one-cycle error pulse.
- err_code  output  2  valid with err: 01 = done window missed, 10 = ack timeout.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - gnt, cli_done, rsc_req, busy, err and err_code all go to 0.
  - The round-robin pointer is set so that client 0 has highest priority.
- All outputs are registered.
- States are IDLE, REQ and WAIT_DONE.
- IDLE:
  - If req != 0 at edge t, the winner is the first set bit searching upward (with wrap) from last_winner+1.
  - At t+1: gnt = onehot(winner), rsc_req = 1, busy = 1, state = REQ.
  - last_winner is updated to the winner.
- REQ:
  - rsc_req stays 1 until rsc_ack is sampled 1 at edge a.
  - At a+1: rsc_req = 0, state = WAIT_DONE, window counter = 0.
  - rsc_done sampled in REQ is ignored, even in the same cycle as rsc_ack, because done must be strictly after ack.
- WAIT_DONE:
  - The counter increments each cycle.
  - Success: rsc_done sampled at a+k, with 1 <= k <= DONE_WIN, means at a+k+1: cli_done[winner] = 1 for one cycle, gnt = 0, busy = 0, state = IDLE.
  - Failure: no rsc_done by a+DONE_WIN means at a+DONE_WIN+1: err = 1, err_code = 01, gnt = 0, busy = 0, state = IDLE, and no cli_done pulse.
  - rsc_ack seen again in WAIT_DONE is ignored.
- Requests during a transaction:
  - If the granted client drops req mid-transaction, there is no abort; the transaction completes normally.
  - Other clients' req are not sampled until IDLE.
- There is always at least one IDLE cycle between transactions. Back-to-back throughput is therefore one grant per (handshake + 1) cycles.
- gnt is always zero or one-hot; it is never changed mid-transaction.
- rsc_req is never 1 outside REQ.
- rsc_done arriving while in IDLE is ignored.

Optional Feature:
- Macro: REQ_ACK_DONE_ARB_ACK_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ.
  - If no rsc_ack within ACK_TIMEOUT cycles of rsc_req rising, the next cycle gives: rsc_req = 0, gnt = 0, err = 1, err_code = 10, state = IDLE.
  - The round-robin pointer still advances past the failed client.
- Undefined:
  - REQ waits indefinitely for ack (strong-eventually semantics).
  - err_code 10 is never produced.

Test Plan:
- Single client: req = 0001 at cycle 0 and ack at cycle 3 -> gnt = 0001 and rsc_req = 1 in cycles 1-3. rsc_req = 0 at cycle 4. With done at cycle 5 -> cli_done = 0001 at cycle 6, busy = 0 at cycle 6.
- Fairness: req = 1111 held, each transaction completes (ack after 1 cycle, done after 1) -> grant order 0001, 0010, 0100, 1000, 0001.
- Done window: ack at cycle a, rsc_done at a+2 -> success. Ack at a, rsc_done first at a+3 -> err = 1 with err_code = 01 at a+3, no cli_done, late done ignored.
- Ack and done in the same cycle -> done ignored. Done again at a+1 -> success.
- Async reset asserted mid-WAIT_DONE -> all outputs 0 immediately without a clock edge. After release, req = 1000 -> client 3 granted. With req = 1001 -> client 0 granted first.
- With REQ_ACK_DONE_ARB_ACK_TIMEOUT_EN and ACK_TIMEOUT = 4, no ack -> err with err_code = 10 after 4 cycles of rsc_req, then the next client is granted after one IDLE cycle.
